// File: rtl/imem_responder_if.sv
// Instruction-memory miss bus between the cache (master) and the memory responder (slave).
interface imem_responder_if #(
    parameter int A_WIDTH = 32
);
    logic [A_WIDTH-1:0] m_a;
    logic               m_strobe;
    logic [31:0]        m_dout;
    logic               m_ready;

    modport master (output m_a, output m_strobe, input m_dout, input m_ready);
    modport slave  (input m_a, input m_strobe, output m_dout, output m_ready);
endinterface

// File: rtl/imem_responder.sv
// Fixed-latency single-word instruction memory responder with a preload write port.
// Optional IMEM_JITTER_EN adds LFSR-driven extra latency of 0..3 cycles per accepted request.
module imem_responder #(
    parameter int A_WIDTH    = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  clrn,
    imem_responder_if.slave       bus,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_a,
    input  logic [31:0]           ld_d
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef IMEM_JITTER_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = 4;
`endif
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [A_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]        dout_reg;
    logic               fetch;
    logic               accept;
    logic               addr_match;
    logic [CNT_W-1:0]   reload;
    logic [31:0]        mem [0:DEPTH-1];

    assign addr_match = (bus.m_a[A_WIDTH-1:2] == addr_reg[A_WIDTH-1:2]);

    // Byte-offset bits never select a word; kept only to document that they are ignored.
    wire unused_low = &{1'b0, bus.m_a[1:0], addr_reg[1:0]};

`ifdef IMEM_JITTER_EN
    logic [7:0] lfsr_reg, lfsr_next;
    logic       lfsr_fb;

    assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign lfsr_next = accept ? {lfsr_reg[6:0], lfsr_fb} : lfsr_reg;
    assign reload    = RELOAD + {3'b000, lfsr_reg[1:0]};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) lfsr_reg <= 8'hA5;
        else       lfsr_reg <= lfsr_next;
    end
`else
    assign reload = RELOAD;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        fetch      = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.m_strobe) begin
                    accept     = 1'b1;
                    addr_next  = bus.m_a;
                    cnt_next   = reload;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.m_strobe) begin
                    state_next = ST_IDLE;
                end else if (!addr_match) begin
                    // Redirected request: restart the full latency on the new address.
                    accept    = 1'b1;
                    addr_next = bus.m_a;
                    cnt_next  = reload;
                end else if (cnt_reg == '0) begin
                    fetch      = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
        end
    end

    // Registered read; a same-edge preload write lands after this read, so the old word wins.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)      dout_reg <= '0;
        else if (fetch) dout_reg <= mem[addr_reg[DEPTH_LOG2+1:2]];
    end

    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_a] <= ld_d;
    end

    assign bus.m_dout  = dout_reg;
    assign bus.m_ready = (state_reg == ST_RESP) && bus.m_strobe && addr_match;
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected responses (cycle, data) are queued at stimulus time.
module tb_imem_responder;
    localparam int A_WIDTH    = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 3;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic                  clk;
    logic                  clrn;
    logic                  ld_we;
    logic [DEPTH_LOG2-1:0] ld_a;
    logic [31:0]           ld_d;
    int                    cyc;
    int                    n_checks;
    int                    n_errors;
    int                    t0;
    exp_t                  exp_q[$];
    logic [31:0]           ref_mem [0:(1<<DEPTH_LOG2)-1];

    imem_responder_if #(.A_WIDTH(A_WIDTH)) bus ();

    imem_responder #(
        .A_WIDTH(A_WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .clrn(clrn), .bus(bus), .ld_we(ld_we), .ld_a(ld_a), .ld_d(ld_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, act, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [DEPTH_LOG2-1:0] a, input logic [31:0] d);
        ld_we = 1'b1;
        ld_a  = a;
        ld_d  = d;
        step(1);
        ld_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_exp(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Response monitor: every m_ready must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("ready_data", bus.m_dout, e.data);
            end
        end
    end

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        clrn = 1'b1; ld_we = 1'b0; ld_a = '0; ld_d = '0;
        bus.m_a = '0; bus.m_strobe = 1'b0;
        #3 clrn = 1'b0;
        step(2);
        check("reset_ready", 32'(bus.m_ready), 32'd0);
        check("reset_dout", bus.m_dout, 32'd0);
        clrn = 1'b1;
        step(1);

        preload(10'd5, 32'hDEADBEEF);
        preload(10'd6, 32'hCAFE0006);
        preload(10'd8, 32'h08080808);
        preload(10'd0, 32'h12345678);
        step(2);

        // Held strobe at 0x14: one ready at +4, re-accepted request abandoned when strobe drops.
        t0 = cyc;
        bus.m_a = 32'h14; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[5]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t1_dout_hold", bus.m_dout, 32'hDEADBEEF);

        // Withdrawn request, then a fresh one at 0x18.
        t0 = cyc;
        bus.m_a = 32'h14; bus.m_strobe = 1'b1;
        step(2);
        bus.m_strobe = 1'b0;
        step(3);
        bus.m_a = 32'h18; bus.m_strobe = 1'b1;
        push_exp(t0 + 9, ref_mem[6]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Redirect 0x14 -> 0x20 while waiting.
        t0 = cyc;
        bus.m_a = 32'h14; bus.m_strobe = 1'b1;
        step(2);
        bus.m_a = 32'h20;
        push_exp(t0 + 6, ref_mem[8]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: address moves to 0x18 right after the first ready.
        t0 = cyc;
        bus.m_a = 32'h14; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[5]);
        push_exp(t0 + 9, ref_mem[6]);
        step(5);
        bus.m_a = 32'h18;
        step(5);
        bus.m_strobe = 1'b0;
        step(6);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Wrap: 0x1000 maps to word 0.
        t0 = cyc;
        bus.m_a = 32'h1000; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[0]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);

        // Preload write to word 0 on the fetch edge: old data expected.
        t0 = cyc;
        bus.m_a = 32'h1000; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[0]);
        step(3);
        ld_we = 1'b1; ld_a = 10'd0; ld_d = 32'h0;
        step(1);
        ld_we = 1'b0;
        ref_mem[0] = 32'h0;
        step(1);
        bus.m_strobe = 1'b0;
        step(6);

        // New value visible afterwards.
        t0 = cyc;
        bus.m_a = 32'h0; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[0]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);

        // Misaligned low bits ignored: 0x17 reads word 5.
        t0 = cyc;
        bus.m_a = 32'h17; bus.m_strobe = 1'b1;
        push_exp(t0 + 4, ref_mem[5]);
        step(5);
        bus.m_strobe = 1'b0;
        step(6);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-request: outputs clear at once, request dropped.
        bus.m_a = 32'h14; bus.m_strobe = 1'b1;
        step(2);
        clrn = 1'b0;
        #1;
        check("midreset_ready", 32'(bus.m_ready), 32'd0);
        check("midreset_dout", bus.m_dout, 32'd0);
        bus.m_strobe = 1'b0;
        step(1);
        clrn = 1'b1;
        step(10);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Memory-side responder for the instruction-cache miss interface; the other end of the cache's m_a / m_strobe / m_dout / m_ready protocol.
- Serves single-word instruction reads from an internal word array after a programmable fixed latency, pulsing m_ready with valid m_dout.
- Used as the instruction-memory model behind the cache in the SoC top and in cache testbenches.
- Has a separate preload write port so benches and the boot loader can fill the array.

Parameters:
- A_WIDTH, 32: address width of m_a.
- DEPTH_LOG2, 10: log2 of array depth in 32-bit words.
- LATENCY, 3: wait cycles between request acceptance and response; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- m_a  in  A_WIDTH  request byte address; bits [1:0] ignored.
- m_strobe  in  1  request valid; held high until m_ready seen or request withdrawn.
- m_dout  out  32  read data; valid when m_ready=1.
- m_ready  out  1  one-cycle response strobe.
- ld_we  in  1  preload write enable.
- ld_a  in  DEPTH_LOG2  preload word index.
- ld_d  in  32  preload data.

Behaviour:
- States: IDLE, WAIT, RESP. Registers: addr_q (A_WIDTH), cnt (4 bits), dout_q (32).
- Reset (clrn=0, asynchronous): state=IDLE, cnt=0, addr_q=0, dout_q=0. Hence m_ready=0 and m_dout=0 immediately. Array contents are not reset.
- IDLE:
  - m_strobe=1 at an edge → addr_q<=m_a, cnt<=LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - m_strobe=0 → IDLE; the request is abandoned and no m_ready is produced.
  - m_strobe=1 with m_a[A_WIDTH-1:2] != addr_q[A_WIDTH-1:2] → restart: addr_q<=m_a, cnt<=LATENCY-1, stay in WAIT.
  - cnt==0 → dout_q<=mem[addr_q[DEPTH_LOG2+1:2]], go to RESP.
  - Otherwise cnt<=cnt-1.
- RESP:
  - m_ready = (state==RESP) & m_strobe & (m_a[A_WIDTH-1:2]==addr_q[A_WIDTH-1:2]). This is combinational from registered state, so a withdrawn or redirected request never sees ready.
  - Unconditionally go to IDLE at the next edge. IDLE samples any new or still-pending strobe, so back-to-back responses are separated by at least one idle cycle.
- m_dout = dout_q at all times; holds its last value between responses.
- Latency: request first high in cycle c0 with a stable address → m_ready high in cycle c0+LATENCY+1, for exactly one cycle.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2]; upper bits ignored, so addresses wrap modulo the array size.
  - Misaligned low bits are ignored.
- Preload:
  - ld_we=1 → mem[ld_a]<=ld_d at the edge, in any state.
  - Same-edge collision with the response fetch: the fetch returns the old word (read-before-write).
- Flushed cache: the cache may keep m_strobe high on the same address after an m_ready it did not consume. This is treated as a new request and served again after full latency.
- Reset mid-operation: the outstanding request is dropped. After clrn rises, the block is in IDLE and re-samples m_strobe.

Optional Feature:
- Macro IMEM_JITTER_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances once per accepted request, i.e. on the IDLE→WAIT transition and on every restart.
  - Its low 2 bits are added to the reload value: cnt<=LATENCY-1+lfsr[1:0].
  - cnt widens to 5 bits, so effective latency is LATENCY..LATENCY+3, deterministic per reset.
- Not defined: no LFSR; latency is exactly LATENCY.

Test Plan:
- Preload mem[5]=32'hDEADBEEF; hold m_a=32'h14, m_strobe=1 from cycle 0, LATENCY=3 → m_ready=1 only in cycle 4, m_dout=32'hDEADBEEF; drop strobe in cycle 5 → m_ready stays 0.
- Strobe at 32'h14 in cycle 0, dropped in cycle 2 → no m_ready ever; new strobe at 32'h18 in cycle 5 → m_ready in cycle 9 with mem[6].
- Strobe at 32'h14, m_a switched to 32'h20 in cycle 2 → no ready for 32'h14; m_ready in cycle 6 with mem[8].
- Assert clrn=0 in cycle 2 of a pending request → m_ready=0 and m_dout=0 the same cycle; after release with strobe low, no m_ready ever.
- Strobe held, address 32'h14 then 32'h18 immediately after the first ready → ready pulses in cycles 4 and 9, exactly one idle cycle between RESP and the next acceptance.
- DEPTH_LOG2=10, mem[0]=32'h12345678, m_a=32'h1000 → m_dout=32'h12345678; with ld_we writing mem[0]=32'h0 on the fetch edge → old value 32'h12345678 returned.
